// File: rtl/memory_stage_if.sv
// EX/MEM/WB pipeline bundle for the memory stage: EX inputs in, M and W stage values out.
interface memory_stage_if;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic [31:0] ALUOutE;
    logic [31:0] WriteDataE;
    logic [4:0]  WriteRegE;

    logic        RegWriteM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [4:0]  WriteRegM;
    logic [31:0] ReadDataM;

    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE,
        input  RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM, ReadDataM,
        input  RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, ResultW
    );

    modport slave (
        input  RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE,
        output RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM, ReadDataM,
        output RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, ResultW
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: EX/MEM register, word-addressed data memory, MEM/WB register, writeback mux.
module memory_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8
) (
    input  logic           clk,
    input  logic           reset,
    memory_stage_if.slave  bus
);
    logic        r_RegWriteM;
    logic        r_MemtoRegM;
    logic        r_MemWriteM;
    logic [31:0] r_ALUOutM;
    logic [31:0] r_WriteDataM;
    logic [4:0]  r_WriteRegM;

    logic        r_RegWriteW;
    logic        r_MemtoRegW;
    logic [31:0] r_ReadDataW;
    logic [31:0] r_ALUOutW;
    logic [4:0]  r_WriteRegW;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]          w_read_data;

    // EX -> MEM boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_RegWriteM  <= 1'b0;
            r_MemtoRegM  <= 1'b0;
            r_MemWriteM  <= 1'b0;
            r_ALUOutM    <= '0;
            r_WriteDataM <= '0;
            r_WriteRegM  <= '0;
        end else begin
            r_RegWriteM  <= bus.RegWriteE;
            r_MemtoRegM  <= bus.MemtoRegE;
            r_MemWriteM  <= bus.MemWriteE;
            r_ALUOutM    <= bus.ALUOutE;
            r_WriteDataM <= bus.WriteDataE;
            r_WriteRegM  <= bus.WriteRegE;
        end
    end

    // Byte offset and high address bits are dropped, so addresses truncate and wrap.
    assign w_idx       = r_ALUOutM[ADDR_BITS+1:2];
    assign w_read_data = r_mem[w_idx];

    // Memory contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (!reset && r_MemWriteM) begin
            r_mem[w_idx] <= r_WriteDataM;
        end
    end

    // MEM -> WB boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_RegWriteW <= 1'b0;
            r_MemtoRegW <= 1'b0;
            r_ReadDataW <= '0;
            r_ALUOutW   <= '0;
            r_WriteRegW <= '0;
        end else begin
            r_RegWriteW <= r_RegWriteM;
            r_MemtoRegW <= r_MemtoRegM;
            r_ReadDataW <= w_read_data;
            r_ALUOutW   <= r_ALUOutM;
            r_WriteRegW <= r_WriteRegM;
        end
    end

    assign bus.RegWriteM  = r_RegWriteM;
    assign bus.MemtoRegM  = r_MemtoRegM;
    assign bus.MemWriteM  = r_MemWriteM;
    assign bus.ALUOutM    = r_ALUOutM;
    assign bus.WriteDataM = r_WriteDataM;
    assign bus.WriteRegM  = r_WriteRegM;
    assign bus.ReadDataM  = w_read_data;

    assign bus.RegWriteW  = r_RegWriteW;
    assign bus.MemtoRegW  = r_MemtoRegW;
    assign bus.ReadDataW  = r_ReadDataW;
    assign bus.ALUOutW    = r_ALUOutW;
    assign bus.WriteRegW  = r_WriteRegW;
    assign bus.ResultW    = r_MemtoRegW ? r_ReadDataW : r_ALUOutW;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_memory_stage;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    memory_stage_if bus ();

    memory_stage #(.DEPTH_WORDS(DEPTH), .ADDR_BITS(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
    } instr_t;

    // Model: the instruction now in M, the one in W, what W loaded, and the words known to memory.
    instr_t      mM, mW;
    logic [31:0] mWrd;
    bit          mWrd_known;
    logic [31:0] mmem [int];

    int n_pass = 0;
    int n_total = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic set_e(input logic rw, input logic mtr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        bus.RegWriteE  = rw;
        bus.MemtoRegE  = mtr;
        bus.MemWriteE  = mw;
        bus.ALUOutE    = alu;
        bus.WriteDataE = wd;
        bus.WriteRegE  = wr;
    endtask

    // Advance one clock and move the instruction stream through the model.
    task automatic tick(input logic rst);
        instr_t e;
        e = '{bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUOutE, bus.WriteDataE, bus.WriteRegE};
        reset = rst;
        @(posedge clk);
        if (rst) begin
            mM = '0;
            mW = '0;
            mWrd = '0;
            mWrd_known = 1'b1;
        end else begin
            mW = mM;
            mWrd_known = mmem.exists(widx(mM.alu));
            mWrd = mWrd_known ? mmem[widx(mM.alu)] : 32'h0;
            if (mM.mw) mmem[widx(mM.alu)] = mM.wd;
            mM = e;
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            set_e(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'hCAFE_F00D, 5'd31);
            tick(1'b1);
            n_total++;
            if ({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.ALUOutM, bus.WriteDataM, bus.WriteRegM} !== '0)
                $display("FAIL reset_M cycle %0d: got rw=%b mtr=%b mw=%b alu=%h wd=%h wr=%0d, need all 0", c,
                         bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.ALUOutM, bus.WriteDataM, bus.WriteRegM);
            else n_pass++;
            n_total++;
            if ({bus.RegWriteW, bus.MemtoRegW, bus.ReadDataW, bus.ALUOutW, bus.WriteRegW} !== '0)
                $display("FAIL reset_W cycle %0d: got rw=%b mtr=%b rd=%h alu=%h wr=%0d, need all 0", c,
                         bus.RegWriteW, bus.MemtoRegW, bus.ReadDataW, bus.ALUOutW, bus.WriteRegW);
            else n_pass++;
            n_total++;
            if (bus.ResultW !== 32'h0) $display("FAIL reset_ResultW cycle %0d: got %h need 0", c, bus.ResultW);
            else n_pass++;
        end
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_store_load;
        set_e(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0);
        tick(1'b0);
        set_e(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
        tick(1'b0);
        n_total++;
        if (bus.ReadDataM !== 32'hDEAD_BEEF) $display("FAIL st_ld_ReadDataM: got %h need deadbeef", bus.ReadDataM);
        else n_pass++;
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick(1'b0);
        n_total++;
        if (bus.ResultW !== 32'hDEAD_BEEF) $display("FAIL st_ld_ResultW: got %h need deadbeef", bus.ResultW);
        else n_pass++;
        n_total++;
        if (bus.WriteRegW !== 5'd5 || bus.RegWriteW !== 1'b1)
            $display("FAIL st_ld_WriteRegW: got wr=%0d rw=%b need wr=5 rw=1", bus.WriteRegW, bus.RegWriteW);
        else n_pass++;
    endtask

    task automatic test_wrap;
        set_e(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 5'd0);
        tick(1'b0);
        set_e(1'b1, 1'b1, 1'b0, 32'h23, 32'h0, 5'd7);
        tick(1'b0);
        n_total++;
        if (bus.ReadDataM !== 32'h1234_5678) $display("FAIL trunc_ReadDataM: got %h need 12345678", bus.ReadDataM);
        else n_pass++;
        set_e(1'b1, 1'b1, 1'b0, 32'h420, 32'h0, 5'd8);
        tick(1'b0);
        n_total++;
        if (bus.ReadDataM !== 32'h1234_5678) $display("FAIL wrap_ReadDataM: got %h need 12345678", bus.ReadDataM);
        else n_pass++;
        n_total++;
        if (bus.ResultW !== 32'h1234_5678) $display("FAIL trunc_ResultW: got %h need 12345678", bus.ResultW);
        else n_pass++;
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick(1'b0);
        n_total++;
        if (bus.ResultW !== 32'h1234_5678) $display("FAIL wrap_ResultW: got %h need 12345678", bus.ResultW);
        else n_pass++;
    endtask

    task automatic test_alu;
        set_e(1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 5'd3);
        tick(1'b0);
        n_total++;
        if (bus.ALUOutM !== 32'h7) $display("FAIL alu_ALUOutM: got %h need 7", bus.ALUOutM);
        else n_pass++;
        set_e(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd4);
        tick(1'b0);
        n_total++;
        if (bus.ResultW !== 32'h7) $display("FAIL alu_ResultW: got %h need 7", bus.ResultW);
        else n_pass++;
        n_total++;
        if (bus.ReadDataM !== 32'hDEAD_BEEF) $display("FAIL alu_mem_intact: got %h need deadbeef", bus.ReadDataM);
        else n_pass++;
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_reset_suppresses_store;
        set_e(1'b0, 1'b0, 1'b1, 32'h40, 32'h5555, 5'd0);
        tick(1'b0);
        set_e(1'b0, 1'b0, 1'b1, 32'h40, 32'hAAAA, 5'd0);
        tick(1'b0);
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick(1'b1);
        set_e(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd9);
        tick(1'b0);
        n_total++;
        if (bus.ReadDataM !== 32'h5555) $display("FAIL rst_store_suppress: got %h need 00005555", bus.ReadDataM);
        else n_pass++;
        n_total++;
        if (bus.WriteRegM !== 5'd9) $display("FAIL rst_no_bubble: got WriteRegM=%0d need 9", bus.WriteRegM);
        else n_pass++;
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_random;
        logic [31:0] exp_res;
        bit          res_known;
        for (int i = 0; i < 300; i++) begin
            set_e(1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 3) << 10),
                  $urandom, 5'($urandom));
            tick(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
            n_total++;
            if ({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.ALUOutM, bus.WriteDataM, bus.WriteRegM} !== mM)
                $display("FAIL rand_M[%0d]: got %h need %h", i,
                         {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.ALUOutM, bus.WriteDataM, bus.WriteRegM}, mM);
            else n_pass++;
            n_total++;
            if ({bus.RegWriteW, bus.MemtoRegW, bus.ALUOutW, bus.WriteRegW} !== {mW.rw, mW.mtr, mW.alu, mW.wr})
                $display("FAIL rand_W[%0d]: got %h need %h", i,
                         {bus.RegWriteW, bus.MemtoRegW, bus.ALUOutW, bus.WriteRegW}, {mW.rw, mW.mtr, mW.alu, mW.wr});
            else n_pass++;
            if (mmem.exists(widx(mM.alu))) begin
                n_total++;
                if (bus.ReadDataM !== mmem[widx(mM.alu)])
                    $display("FAIL rand_ReadDataM[%0d]: got %h need %h", i, bus.ReadDataM, mmem[widx(mM.alu)]);
                else n_pass++;
            end
            res_known = !mW.mtr || mWrd_known;
            exp_res = mW.mtr ? mWrd : mW.alu;
            if (res_known) begin
                n_total++;
                if (bus.ResultW !== exp_res) $display("FAIL rand_ResultW[%0d]: got %h need %h", i, bus.ResultW, exp_res);
                else n_pass++;
            end
        end
    endtask

    initial begin
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        mM = '0;
        mW = '0;
        mWrd = '0;
        mWrd_known = 1'b1;
        test_reset();
        test_store_load();
        test_wrap();
        test_alu();
        test_reset_suppresses_store();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL expose parameter DEPTH_WORDS, default 256, giving the number of 32-bit data-memory words; it is a power of two.
REQ-002 The block SHALL expose parameter ADDR_BITS, default 8, equal to log2(DEPTH_WORDS).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RegWriteE  input  1  the EX instruction writes the register file.
REQ-006 MemtoRegE  input  1  the EX instruction's result comes from memory (load).
REQ-007 MemWriteE  input  1  the EX instruction stores to memory.
REQ-008 ALUOutE  input  32  the EX ALU result, used as the byte address for loads and stores.
REQ-009 WriteDataE  input  32  the EX store data, after forwarding.
REQ-010 WriteRegE  input  5  the EX destination register.
REQ-011 RegWriteM, MemtoRegM, MemWriteM  output  1 each  EX/MEM registered controls.
REQ-012 ALUOutM  output  32  registered ALU result, also the forwarding source for EX.
REQ-013 WriteDataM  output  32  registered store data.
REQ-014 WriteRegM  output  5  registered destination, for the hazard unit.
REQ-015 ReadDataM  output  32  combinational data-memory read.
REQ-016 RegWriteW, MemtoRegW  output  1 each  MEM/WB registered controls.
REQ-017 ReadDataW, ALUOutW  output  32 each  MEM/WB registered data.
REQ-018 WriteRegW  output  5  MEM/WB destination register.
REQ-019 ResultW  output  32  writeback result, also the forwarding source for EX.

Function
REQ-020 On each rising clk edge without reset, the EX/MEM register SHALL capture all *E inputs into the matching *M outputs, giving 1-cycle latency.
REQ-021 On each rising clk edge without reset, the MEM/WB register SHALL capture RegWriteM, MemtoRegM, ALUOutM, ReadDataM and WriteRegM into the matching *W outputs, giving 2-cycle latency from the E inputs to W.
REQ-022 The word index SHALL be ALUOutM[ADDR_BITS+1:2].
- ALUOutM[1:0] is ignored: addresses are word-aligned by truncation.
- Address bits above ADDR_BITS+1 are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-023 ReadDataM SHALL be a combinational read of mem[index] and is valid whether or not the instruction is a load.
REQ-024 When MemWriteM=1 at a rising edge and reset=0, the block SHALL write WriteDataM to mem[index].
REQ-025 Read during a write: in the same cycle, ReadDataM SHALL show the old contents; the new value SHALL be visible from the cycle after the edge.
- A load directly following a store to the same word therefore returns the stored data.
REQ-026 ResultW SHALL be combinational: ReadDataW when MemtoRegW=1, else ALUOutW.
REQ-027 The block SHALL have no stall or flush inputs; every cycle advances both registers.

Reset
REQ-028 While reset=1 at a rising edge, both registers SHALL clear: all *M and *W outputs become 0, so ResultW=0.
REQ-029 Reset SHALL suppress any memory write in the same cycle, including a store already in M.
REQ-030 Reset SHALL NOT clear data-memory contents; words not yet written are undefined (X in simulation).
REQ-031 On the first rising edge after reset deasserts, normal capture SHALL resume with no extra bubble.

Verification
REQ-032 Reset held 2 cycles with nonzero E inputs -> all M and W outputs 0 and ResultW=0 after each edge.
REQ-033 Store ALUOutE=0x10, WriteDataE=0xDEADBEEF, MemWriteE=1, then a load from 0x10 (MemtoRegE=1, RegWriteE=1, WriteRegE=5) on the next cycle -> ReadDataM=0xDEADBEEF one cycle after the load enters; two cycles after, ResultW=0xDEADBEEF and WriteRegW=5.
REQ-034 Store 0x12345678 to 0x20, then load from 0x23, then load from 0x420 (DEPTH_WORDS=256) -> both loads return 0x12345678 (truncation and wrap).
REQ-035 ALU instruction with ALUOutE=0x7, MemtoRegE=0, RegWriteE=1 -> ALUOutM=0x7 after 1 edge and ResultW=0x7 after 2 edges; no memory word changes.
REQ-036 Store 0xAAAA to 0x40 with reset asserted on the edge where MemWriteM=1, then a load from 0x40 after reset -> location not updated (prior value or X); the store is suppressed.
